// File: rtl/decrypt_pkg.sv
// Shared constants, FSM state encoding and LFSR helpers for the program-3
// decrypt engine (top_level / data_mem).
// Optional build macro STORE_KEY_EN: the recovered key is also written to
// DM[137] (tap) and DM[138] (seed).
package decrypt_pkg;

  localparam logic [6:0] MSG_LEN       = 7'd64;   // message length in bytes
  localparam logic [7:0] CT_BASE       = 8'd64;   // ciphertext byte 0
  localparam logic [7:0] TAP_BASE      = 8'd128;  // tap-pattern table
  localparam logic [3:0] NUM_TAPS      = 4'd9;    // candidate tap patterns
  localparam logic [3:0] PRE_MIN       = 4'd10;   // guaranteed leading spaces
  localparam int         DM_DEPTH      = 256;     // data memory bytes
  localparam logic [7:0] KEY_TAP_ADDR  = 8'd137;  // recovered tap slot
  localparam logic [7:0] KEY_SEED_ADDR = 8'd138;  // recovered seed slot
  localparam logic [6:0] SPACE7        = 7'h20;
  localparam logic [7:0] SPACE8        = 8'h20;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SEED   = 3'd1,
    S_SEARCH = 3'd2,
    S_SCAN   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // One Fibonacci LFSR step: shift left, feedback is the parity of tapped bits.
  function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] tap);
    lfsr_step = {s[5:0], ^(s & tap)};
  endfunction

  // Parity over a full byte; 1 means the stored even parity is broken.
  function automatic logic parity8(input logic [7:0] b);
    parity8 = ^b;
  endfunction

endpackage

// File: rtl/data_mem.sv
// 256x8 data memory: one synchronous write port, one combinational read port.
// No reset: contents are loaded from outside and must survive engine resets.
module data_mem
  import decrypt_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_we,
  input  logic [7:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [7:0] i_raddr,
  output logic [7:0] o_rdata
);

  logic [7:0] Core [0:DM_DEPTH-1];

  // Byte write on the rising edge when enabled.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      Core[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = Core[i_raddr];

endmodule

// File: rtl/top_level.sv
// Program-3 decrypt engine: recovers the 7-bit LFSR key of a 64-byte
// parity-tagged ciphertext, decrypts it, flags parity-bad bytes in the MSB,
// strips leading spaces and writes the result to DM[0..63].
// Optional build macro STORE_KEY_EN: on entering WRITE the found tap and seed
// are first written to DM[137] and DM[138] (two extra clocks).
module top_level
  import decrypt_pkg::*;
(
  input  logic Clk,
  input  logic Reset,
  input  logic Start,
  output logic Ack
);

  state_t     r_state;
  state_t     w_state_nxt;

  logic [6:0] r_seed;    // recovered seed (key[0])
  logic [6:0] r_key;     // key of the byte currently being read
  logic [7:0] r_tap;     // tap pattern under test / found
  logic [3:0] r_p;       // tap table index
  logic [3:0] r_i;       // search byte index, 0 = fetch tap
  logic       r_force;   // no pattern matched: fall back to entry 0
  logic [6:0] r_j;       // ciphertext index (scan position, then n+lead)
  logic [5:0] r_n;       // output slot
  logic       r_ack;

  logic [7:0] w_raddr;
  logic [7:0] w_rdata;
  logic [7:0] w_waddr;
  logic [7:0] w_wdata;
  logic       w_we;
  logic [6:0] w_pt7;
  logic       w_is_space;
  logic       w_par_bad;
  logic       w_key_phase;  // WRITE is still storing key bytes
  logic       w_key_sel;    // 0 = tap byte, 1 = seed byte

`ifdef STORE_KEY_EN
  logic [1:0] r_kcnt;
  assign w_key_phase = (r_kcnt != 2'd2);
  assign w_key_sel   = r_kcnt[0];
`else
  assign w_key_phase = 1'b0;
  assign w_key_sel   = 1'b0;
`endif

  data_mem DM (
    .i_clk   (Clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign w_pt7      = w_rdata[6:0] ^ r_key;
  assign w_is_space = (w_pt7 == SPACE7);
  assign w_par_bad  = parity8(w_rdata);
  assign Ack        = r_ack;

  // Next-state, memory address and write-port control.
  always_comb begin
    w_state_nxt = r_state;
    w_raddr     = CT_BASE + {2'b00, r_j[5:0]};
    w_we        = 1'b0;
    w_waddr     = {2'b00, r_n};
    w_wdata     = SPACE8;
    case (r_state)
      S_IDLE: begin
        if (!Start) begin
          w_state_nxt = S_SEED;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SEED: begin
        w_raddr     = CT_BASE;
        w_state_nxt = S_SEARCH;
      end
      S_SEARCH: begin
        if (r_i == 4'd0) begin
          w_raddr = TAP_BASE + {4'b0000, r_p};
          if (r_force) begin
            w_state_nxt = S_SCAN;
          end else begin
            w_state_nxt = S_SEARCH;
          end
        end else begin
          w_raddr = CT_BASE + {4'b0000, r_i};
          if (w_is_space && (r_i == (PRE_MIN - 4'd1))) begin
            w_state_nxt = S_SCAN;
          end else begin
            w_state_nxt = S_SEARCH;
          end
        end
      end
      S_SCAN: begin
        if (w_is_space && !w_par_bad && (r_j != 7'd63)) begin
          w_state_nxt = S_SCAN;
        end else begin
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        w_we = 1'b1;
        if (w_key_phase) begin
          if (w_key_sel) begin
            w_waddr = KEY_SEED_ADDR;
            w_wdata = {1'b0, r_seed};
          end else begin
            w_waddr = KEY_TAP_ADDR;
            w_wdata = r_tap;
          end
          w_state_nxt = S_WRITE;
        end else begin
          if (r_j[6]) begin
            w_wdata = SPACE8;
          end else begin
            w_wdata = {w_par_bad, w_pt7};
          end
          if ({1'b0, r_n} == (MSG_LEN - 7'd1)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_WRITE;
          end
        end
      end
      S_DONE: begin
        if (Start) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered done flag: high exactly while the FSM sits in DONE.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ack <= 1'b0;
    end else begin
      r_ack <= (w_state_nxt == S_DONE);
    end
  end

  // Key search, scan and depad datapath registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_seed  <= 7'd0;
      r_key   <= 7'd0;
      r_tap   <= 8'd0;
      r_p     <= 4'd0;
      r_i     <= 4'd0;
      r_force <= 1'b0;
      r_j     <= 7'd0;
      r_n     <= 6'd0;
`ifdef STORE_KEY_EN
      r_kcnt  <= 2'd0;
`endif
    end else begin
      case (r_state)
        S_SEED: begin
          r_seed  <= w_rdata[6:0] ^ SPACE7;
          r_p     <= 4'd0;
          r_i     <= 4'd0;
          r_force <= 1'b0;
        end
        S_SEARCH: begin
          if (r_i == 4'd0) begin
            // Tap fetch; on fallback this is entry 0 and the scan starts.
            r_tap <= w_rdata;
            if (r_force) begin
              r_key <= r_seed;
              r_j   <= 7'd0;
            end else begin
              r_key <= lfsr_step(r_seed, w_rdata[6:0]);
              r_i   <= 4'd1;
            end
          end else if (w_is_space) begin
            if (r_i == (PRE_MIN - 4'd1)) begin
              r_key <= r_seed;
              r_j   <= 7'd0;
            end else begin
              r_key <= lfsr_step(r_key, r_tap[6:0]);
              r_i   <= r_i + 4'd1;
            end
          end else begin
            r_i <= 4'd0;
            if (r_p == (NUM_TAPS - 4'd1)) begin
              r_p     <= 4'd0;
              r_force <= 1'b1;
            end else begin
              r_p <= r_p + 4'd1;
            end
          end
        end
        S_SCAN: begin
          // On exit r_j holds lead and r_key holds key[lead].
          r_n <= 6'd0;
`ifdef STORE_KEY_EN
          r_kcnt <= 2'd0;
`endif
          if (w_is_space && !w_par_bad) begin
            r_j   <= r_j + 7'd1;
            r_key <= lfsr_step(r_key, r_tap[6:0]);
          end else begin
            r_j   <= r_j;
            r_key <= r_key;
          end
        end
        S_WRITE: begin
          if (w_key_phase) begin
`ifdef STORE_KEY_EN
            r_kcnt <= r_kcnt + 2'd1;
`endif
          end else begin
            r_n   <= r_n + 6'd1;
            r_j   <= r_j + 7'd1;
            r_key <= lfsr_step(r_key, r_tap[6:0]);
          end
        end
        default: begin
          r_n <= r_n;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_top_level.sv
// Self-checking bench for top_level: table of directed messages encrypted
// by the bench, expected plaintext written out by hand, plus a reset-mid-run
// sequence.
module tb_top_level;
  import decrypt_pkg::*;

  logic Clk = 1'b0;
  logic Reset;
  logic Start;
  logic Ack;

  top_level dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .Ack   (Ack)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int         tap_idx;
    logic [6:0] seed;
    int         pre;
    int         msg_id;
    int         flip_byte;
    logic [15:0] flip_mask;
    int         exp_id;
    int         exp_slot;
    logic [7:0] exp_slot_val;
  } vec_t;

  localparam int NVEC = 7;
  vec_t       vecs [NVEC];
  string      msgs [5];
  string      exps [5];
  logic [7:0] taps [9];
  logic [7:0] ct_img [64];
  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [6:0] enc_step(input logic [6:0] s, input logic [6:0] t);
    logic [6:0] x;
    x = s & t;
    enc_step = {s[5:0], x[0] ^ x[1] ^ x[2] ^ x[3] ^ x[4] ^ x[5] ^ x[6]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_vec(input int v);
    logic [7:0] pt [64];
    logic [6:0] k;
    logic [6:0] c7;
    logic [6:0] tp;
    string m;
    m = msgs[vecs[v].msg_id];
    for (int i = 0; i < 64; i++) pt[i] = 8'h20;
    for (int i = 0; i < m.len(); i++) begin
      if (vecs[v].pre + i < 64) pt[vecs[v].pre + i] = m[i];
    end
    k  = vecs[v].seed;
    tp = taps[vecs[v].tap_idx][6:0];
    for (int i = 0; i < 64; i++) begin
      c7 = pt[i][6:0] ^ k;
      ct_img[i] = {^c7, c7};
      k = enc_step(k, tp);
    end
    if (vecs[v].flip_byte >= 0) begin
      ct_img[vecs[v].flip_byte] = ct_img[vecs[v].flip_byte] ^ vecs[v].flip_mask[7:0];
    end
    for (int i = 0; i < 64; i++) begin
      dut.DM.Core[i]      = 8'hEE;
      dut.DM.Core[64 + i] = ct_img[i];
    end
    for (int i = 0; i < 9; i++) dut.DM.Core[128 + i] = taps[i];
    dut.DM.Core[137] = 8'hA5;
    dut.DM.Core[138] = 8'h5A;
  endtask

  task automatic run_to_ack(input string tag);
    int cyc;
    cyc = 0;
    Start = 1'b0;
    while (!Ack && cyc < 2000) begin
      @(negedge Clk);
      cyc++;
    end
    check($sformatf("%s ack_seen", tag), {31'd0, Ack}, 32'd1);
    check($sformatf("%s latency_le_1200", tag), {31'd0, (cyc <= 1200)}, 32'd1);
  endtask

  task automatic check_out(input int v, input string tag);
    string      e;
    logic [7:0] ex;
    int         bad;
    e = exps[vecs[v].exp_id];
    for (int n = 0; n < 64; n++) begin
      if (n < e.len()) ex = e[n];
      else ex = 8'h20;
      if (n == vecs[v].exp_slot) ex = vecs[v].exp_slot_val;
      check($sformatf("%s DM[%0d]", tag, n), {24'd0, dut.DM.Core[n]}, {24'd0, ex});
    end
    bad = 0;
    for (int i = 0; i < 64; i++) if (dut.DM.Core[64 + i] !== ct_img[i]) bad++;
    for (int i = 0; i < 9; i++) if (dut.DM.Core[128 + i] !== taps[i]) bad++;
    check($sformatf("%s ct_taps_intact", tag), bad, 32'd0);
`ifdef STORE_KEY_EN
    check($sformatf("%s key_tap", tag), {24'd0, dut.DM.Core[137]}, {24'd0, taps[vecs[v].tap_idx]});
    check($sformatf("%s key_seed", tag), {24'd0, dut.DM.Core[138]}, {25'd0, vecs[v].seed});
`else
    check($sformatf("%s slot137", tag), {24'd0, dut.DM.Core[137]}, 32'hA5);
    check($sformatf("%s slot138", tag), {24'd0, dut.DM.Core[138]}, 32'h5A);
`endif
  endtask

  initial begin
    int  found;
    taps = '{8'h60, 8'h48, 8'h78, 8'h72, 8'h6A, 8'h69, 8'h5C, 8'h7E, 8'h7B};
    msgs[0] = "Mr. Watson, come here.";
    msgs[1] = "     0123456789";
    msgs[2] = "Hi!";
    msgs[3] = "";
    msgs[4] = "AB";
    exps[0] = "Mr. Watson, come here.";
    exps[1] = "0123456789";
    exps[2] = "Hi!";
    exps[3] = "";
    exps[4] = "    AB";
    //          tap seed   pre msg flip mask      exp slot val
    vecs[0] = '{0, 7'h01, 10, 0, -1, 16'h0000, 0, -1, 8'h00};  // basic
    vecs[1] = '{8, 7'h55, 15, 1, -1, 16'h0000, 1, -1, 8'h00};  // last tap, spaces in msg
    vecs[2] = '{0, 7'h01, 10, 0, 30, 16'h0008, 0, 20, 8'hED};  // bit 3 of byte 30
    vecs[3] = '{0, 7'h01, 10, 0, 30, 16'h0100, 0, -1, 8'h00};  // flip above byte: no-op
    vecs[4] = '{3, 7'h7F, 10, 2, -1, 16'h0000, 2, -1, 8'h00};  // other tap
    vecs[5] = '{5, 7'h33, 15, 3, -1, 16'h0000, 3, -1, 8'h00};  // all spaces, lead 64
    vecs[6] = '{2, 7'h2A, 30, 4, 26, 16'h0002, 4, 0, 8'hA2};   // parity stops the scan

    Reset = 1'b1;
    Start = 1'b1;
    repeat (3) @(negedge Clk);
    check("reset ack", {31'd0, Ack}, 32'd0);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    check("idle_hold ack", {31'd0, Ack}, 32'd0);

    for (int v = 0; v < NVEC; v++) begin
      load_vec(v);
      run_to_ack($sformatf("vec%0d", v));
      check_out(v, $sformatf("vec%0d", v));
      repeat (4) @(negedge Clk);
      check($sformatf("vec%0d ack_held", v), {31'd0, Ack}, 32'd1);
      Start = 1'b1;
      @(negedge Clk);
      check($sformatf("vec%0d ack_clear", v), {31'd0, Ack}, 32'd0);
      @(negedge Clk);
    end

    // Reset in the middle of WRITE, then a full rerun.
    load_vec(0);
    Start = 1'b0;
    found = 0;
    for (int c = 0; c < 300 && found == 0; c++) begin
      @(negedge Clk);
      if (dut.r_state == S_WRITE) found = 1;
    end
    check("midrun reached_write", found, 32'd1);
    repeat (8) @(negedge Clk);
    Reset = 1'b1;
    Start = 1'b1;
    @(negedge Clk);
    check("midrun reset_ack", {31'd0, Ack}, 32'd0);
    check("midrun reset_idle", {31'd0, (dut.r_state == S_IDLE)}, 32'd1);
    Reset = 1'b0;
    @(negedge Clk);
    check("midrun idle_ack", {31'd0, Ack}, 32'd0);
    run_to_ack("rerun");
    check_out(0, "rerun");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
